// File: rtl/reg_seq.sv
// Micro-sequencer expanding one accepted command into 1-3 cycles of one-hot
// register-bank strobes, ALU control and immediate-driver control.
module reg_seq #(
    parameter int NREG = 4,
    parameter int RW   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [2:0]      cmd_op,
    input  logic [RW-1:0]   cmd_dst,
    input  logic [RW-1:0]   cmd_src_a,
    input  logic [RW-1:0]   cmd_src_b,
    input  logic [2:0]      cmd_aluop,
    input  logic [7:0]      cmd_imm,
    output logic [NREG-1:0] rdata,
    output logic [NREG-1:0] wdata,
    output logic [NREG-1:0] raddr,
    output logic [NREG-1:0] waddr,
    output logic [NREG-1:0] alu_r_a,
    output logic [NREG-1:0] alu_r_b,
    output logic [NREG-1:0] alu_w,
    output logic [2:0]      alu_op,
    output logic            alu_latch,
    output logic            imm_oe,
    output logic [7:0]      imm_data,
    output logic            done,
    output logic            err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EX1  = 2'd1,
        EX2  = 2'd2,
        EX3  = 2'd3
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_MOV  = 3'd1;
    localparam logic [2:0] OP_AMOV = 3'd2;
    localparam logic [2:0] OP_ALU  = 3'd3;
    localparam logic [2:0] OP_SWAP = 3'd4;
    localparam logic [2:0] OP_LDI  = 3'd5;
    localparam logic [2:0] ALU_PASS_A = 3'd0;

    // Indices that do not name a register decode to an all-zero strobe.
    function automatic logic [NREG-1:0] onehot(input logic [RW-1:0] idx);
        logic [NREG-1:0] v;
        v = '0;
        for (int i = 0; i < NREG; i++) begin
            if (int'(idx) == i) begin
                v[i] = 1'b1;
            end else begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

    state_t          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [RW-1:0]   dst_q, dst_d;
    logic [RW-1:0]   src_a_q, src_a_d;
    logic [RW-1:0]   src_b_q, src_b_d;
    logic [2:0]      aluop_q, aluop_d;
    logic [7:0]      imm_q, imm_d;

    logic            cmd_ready_q, cmd_ready_d;
    logic [NREG-1:0] rdata_q, rdata_d;
    logic [NREG-1:0] wdata_q, wdata_d;
    logic [NREG-1:0] raddr_q, raddr_d;
    logic [NREG-1:0] waddr_q, waddr_d;
    logic [NREG-1:0] alu_r_a_q, alu_r_a_d;
    logic [NREG-1:0] alu_r_b_q, alu_r_b_d;
    logic [NREG-1:0] alu_w_q, alu_w_d;
    logic [2:0]      alu_op_q, alu_op_d;
    logic            alu_latch_q, alu_latch_d;
    logic            imm_oe_q, imm_oe_d;
    logic [7:0]      imm_data_q, imm_data_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    // Next state and command latch; fields are captured only on acceptance.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        dst_d   = dst_q;
        src_a_d = src_a_q;
        src_b_d = src_b_q;
        aluop_d = aluop_q;
        imm_d   = imm_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    state_d = EX1;
                    op_d    = cmd_op;
                    dst_d   = cmd_dst;
                    src_a_d = cmd_src_a;
                    src_b_d = cmd_src_b;
                    aluop_d = cmd_aluop;
                    imm_d   = cmd_imm;
                end else begin
                    state_d = IDLE;
                end
            end
            EX1: begin
                if ((op_q == OP_ALU) || (op_q == OP_SWAP)) begin
                    state_d = EX2;
                end else begin
                    state_d = IDLE;
                end
            end
            EX2: begin
                if (op_q == OP_SWAP) begin
                    state_d = EX3;
                end else begin
                    state_d = IDLE;
                end
            end
            EX3:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Decode next-cycle strobes so every output leaves a flop.
    always_comb begin
        cmd_ready_d = (state_d == IDLE);
        rdata_d     = '0;
        wdata_d     = '0;
        raddr_d     = '0;
        waddr_d     = '0;
        alu_r_a_d   = '0;
        alu_r_b_d   = '0;
        alu_w_d     = '0;
        alu_op_d    = alu_op_q;
        alu_latch_d = 1'b0;
        imm_oe_d    = 1'b0;
        imm_data_d  = 8'h00;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_d)
            EX1: begin
                case (op_d)
                    OP_NOP: done_d = 1'b1;
                    OP_MOV: begin
                        rdata_d = onehot(src_a_d);
                        wdata_d = onehot(dst_d);
                        done_d  = 1'b1;
                    end
                    OP_AMOV: begin
                        raddr_d = onehot(src_a_d);
                        waddr_d = onehot(dst_d);
                        done_d  = 1'b1;
                    end
                    OP_ALU: begin
                        alu_r_a_d   = onehot(src_a_d);
                        alu_r_b_d   = onehot(src_b_d);
                        alu_op_d    = aluop_d;
                        alu_latch_d = 1'b1;
                    end
                    OP_SWAP: begin
                        alu_r_a_d   = onehot(src_a_d);
                        alu_op_d    = ALU_PASS_A;
                        alu_latch_d = 1'b1;
                    end
                    OP_LDI: begin
                        imm_oe_d   = 1'b1;
                        imm_data_d = imm_d;
                        wdata_d    = onehot(dst_d);
                        done_d     = 1'b1;
                    end
                    default: begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
                endcase
            end
            EX2: begin
                case (op_d)
                    OP_ALU: begin
                        alu_w_d = onehot(dst_d);
                        done_d  = 1'b1;
                    end
                    OP_SWAP: begin
                        // Second leg: b moves to a while a's old value waits in the ALU latch.
                        rdata_d = onehot(src_b_d);
                        wdata_d = onehot(src_a_d);
                    end
                    default: done_d = 1'b0;
                endcase
            end
            EX3: begin
                alu_w_d = onehot(src_b_d);
                done_d  = 1'b1;
            end
            default: done_d = 1'b0;
        endcase
    end

    // State and latched command registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= 3'd0;
            dst_q   <= '0;
            src_a_q <= '0;
            src_b_q <= '0;
            aluop_q <= 3'd0;
            imm_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dst_q   <= dst_d;
            src_a_q <= src_a_d;
            src_b_q <= src_b_d;
            aluop_q <= aluop_d;
            imm_q   <= imm_d;
        end
    end

    // Output registers; reset clears every strobe at once, aborting any command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready_q <= 1'b1;
            rdata_q     <= '0;
            wdata_q     <= '0;
            raddr_q     <= '0;
            waddr_q     <= '0;
            alu_r_a_q   <= '0;
            alu_r_b_q   <= '0;
            alu_w_q     <= '0;
            alu_op_q    <= 3'd0;
            alu_latch_q <= 1'b0;
            imm_oe_q    <= 1'b0;
            imm_data_q  <= 8'h00;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cmd_ready_q <= cmd_ready_d;
            rdata_q     <= rdata_d;
            wdata_q     <= wdata_d;
            raddr_q     <= raddr_d;
            waddr_q     <= waddr_d;
            alu_r_a_q   <= alu_r_a_d;
            alu_r_b_q   <= alu_r_b_d;
            alu_w_q     <= alu_w_d;
            alu_op_q    <= alu_op_d;
            alu_latch_q <= alu_latch_d;
            imm_oe_q    <= imm_oe_d;
            imm_data_q  <= imm_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rdata     = rdata_q;
    assign wdata     = wdata_q;
    assign raddr     = raddr_q;
    assign waddr     = waddr_q;
    assign alu_r_a   = alu_r_a_q;
    assign alu_r_b   = alu_r_b_q;
    assign alu_w     = alu_w_q;
    assign alu_op    = alu_op_q;
    assign alu_latch = alu_latch_q;
    assign imm_oe    = imm_oe_q;
    assign imm_data  = imm_data_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_reg_seq.sv
// Directed bench for reg_seq with a small behavioural register bank and ALU latch.
module tb_reg_seq;

    localparam int NREG = 4;
    localparam int RW   = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [2:0]      cmd_op;
    logic [RW-1:0]   cmd_dst, cmd_src_a, cmd_src_b;
    logic [2:0]      cmd_aluop;
    logic [7:0]      cmd_imm;
    logic [NREG-1:0] rdata, wdata, raddr, waddr, alu_r_a, alu_r_b, alu_w;
    logic [2:0]      alu_op;
    logic            alu_latch, imm_oe, done, err;
    logic [7:0]      imm_data;

    int vectors     = 0;
    int miscompares = 0;
    logic inv_en     = 1'b0;
    logic watch      = 1'b0;
    logic alu_w_seen = 1'b0;

    reg_seq #(.NREG(NREG), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dst(cmd_dst), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b),
        .cmd_aluop(cmd_aluop), .cmd_imm(cmd_imm),
        .rdata(rdata), .wdata(wdata), .raddr(raddr), .waddr(waddr),
        .alu_r_a(alu_r_a), .alu_r_b(alu_r_b), .alu_w(alu_w),
        .alu_op(alu_op), .alu_latch(alu_latch),
        .imm_oe(imm_oe), .imm_data(imm_data), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural register bank: buses are wired-OR of the enabled drivers.
    logic [7:0] regs [NREG];
    logic [7:0] alu_res;
    logic [7:0] dbus, abus, bus_a, bus_b;

    always_comb begin
        dbus  = imm_oe ? imm_data : 8'h00;
        abus  = 8'h00;
        bus_a = 8'h00;
        bus_b = 8'h00;
        for (int i = 0; i < NREG; i++) begin
            dbus  = dbus  | (rdata[i]   ? regs[i] : 8'h00);
            abus  = abus  | (raddr[i]   ? regs[i] : 8'h00);
            bus_a = bus_a | (alu_r_a[i] ? regs[i] : 8'h00);
            bus_b = bus_b | (alu_r_b[i] ? regs[i] : 8'h00);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (wdata[i]) regs[i] <= dbus;
            if (waddr[i]) regs[i] <= abus;
            if (alu_w[i]) regs[i] <= alu_res;
        end
        if (alu_latch) alu_res <= (alu_op == 3'd0) ? bus_a : (bus_a + bus_b);
        if (watch && (alu_w != '0)) alu_w_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [RW-1:0] dst,
                         input logic [RW-1:0] a, input logic [RW-1:0] b,
                         input logic [2:0] aop, input logic [7:0] imm);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_dst   = dst;
        cmd_src_a = a;
        cmd_src_b = b;
        cmd_aluop = aop;
        cmd_imm   = imm;
    endtask

    // Bus and strobe invariants, sampled on the falling edge.
    always @(negedge clk) begin
        if (inv_en) begin
            check("inv_onehot",
                  {31'd0, $onehot0(rdata) && $onehot0(wdata) && $onehot0(raddr) &&
                          $onehot0(waddr) && $onehot0(alu_r_a) && $onehot0(alu_r_b) &&
                          $onehot0(alu_w)}, 32'd1);
            check("inv_bus",
                  {31'd0, !((rdata != '0) && imm_oe) && ((wdata & waddr) == '0) &&
                          ((alu_w & (wdata | waddr)) == '0) && (imm_oe || imm_data == 8'h00)},
                  32'd1);
        end
    end

    initial begin
        rst_n = 1'b0;
        issue(3'd0, 2'd0, 2'd0, 2'd0, 3'd0, 8'h00);
        cmd_valid = 1'b0;
        #12;
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_strobes", {4'd0, rdata, wdata, raddr, waddr, alu_r_a, alu_r_b, alu_w}, 32'd0);
        check("rst_misc", {20'd0, alu_op, alu_latch, imm_oe, imm_data, done, err}, 32'd0);
        rst_n = 1'b1;
        step();

        // MOV r1 <- r2
        issue(3'd1, 2'd1, 2'd2, 2'd0, 3'd0, 8'h00);
        step();
        cmd_valid = 1'b0;
        check("mov_ex1", {20'd0, rdata, wdata, 1'b0, done, cmd_ready, 1'b0}, {20'd0, 4'b0100, 4'b0010, 4'b0100});
        step();
        check("mov_idle", {30'd0, cmd_ready, done}, 32'd2);

        // ALU r3 <- r0 op5 r1
        issue(3'd3, 2'd3, 2'd0, 2'd1, 3'd5, 8'h00);
        step();
        cmd_valid = 1'b0;
        check("alu_ex1", {16'd0, alu_r_a, alu_r_b, 1'b0, alu_op, 3'd0, alu_latch},
              {16'd0, 4'b0001, 4'b0010, 4'd5, 4'd1});
        step();
        check("alu_ex2", {20'd0, alu_w, alu_r_a, alu_r_b}, {20'd0, 4'b1000, 8'd0});
        check("alu_ex2_done", {30'd0, done, alu_latch}, 32'd2);
        step();
        check("alu_op_hold", {29'd0, alu_op}, 32'd5);

        // Preload r0=0x11, r3=0xA5 then SWAP r0,r3
        issue(3'd5, 2'd0, 2'd0, 2'd0, 3'd0, 8'h11);
        step();
        cmd_valid = 1'b0;
        step();
        issue(3'd5, 2'd3, 2'd0, 2'd0, 3'd0, 8'hA5);
        step();
        cmd_valid = 1'b0;
        step();
        issue(3'd4, 2'd0, 2'd0, 2'd3, 3'd6, 8'h00);
        step();
        issue(3'd1, 2'd1, 2'd1, 2'd1, 3'd7, 8'hFF);
        cmd_valid = 1'b0;
        check("swap_ex1", {20'd0, alu_r_a, 1'b0, alu_op, 3'd0, alu_latch, done},
              {20'd0, 4'b0001, 4'd0, 3'd0, 1'b1, 1'b0});
        step();
        check("swap_ex2", {20'd0, rdata, wdata, 3'd0, done}, {20'd0, 4'b1000, 4'b0001, 4'd0});
        step();
        check("swap_ex3", {24'd0, alu_w, 3'd0, done}, {24'd0, 4'b1000, 4'd1});
        step();
        check("swap_regs", {16'd0, regs[0], regs[3]}, {16'd0, 8'hA5, 8'h11});
        check("swap_ready", {31'd0, cmd_ready}, 32'd1);

        // LDI r2 <- 0x5C with valid held, then MOV r3 <- r2 right behind it
        issue(3'd5, 2'd2, 2'd0, 2'd0, 3'd0, 8'h5C);
        step();
        check("ldi_ex1", {16'd0, 3'd0, imm_oe, imm_data, wdata}, {16'd0, 4'd1, 8'h5C, 4'b0100});
        check("ldi_ready", {30'd0, cmd_ready, done}, 32'd1);
        issue(3'd1, 2'd3, 2'd2, 2'd0, 3'd0, 8'h00);
        step();
        check("b2b_idle", {22'd0, cmd_ready, done, rdata, wdata}, {22'd0, 2'b10, 8'd0});
        check("ldi_reg", {24'd0, regs[2]}, 32'h5C);
        step();
        cmd_valid = 1'b0;
        check("b2b_mov", {23'd0, done, rdata, wdata}, {23'd0, 1'b1, 4'b0100, 4'b1000});
        step();
        check("mov_reg", {24'd0, regs[3]}, 32'h5C);

        // Illegal op 7
        issue(3'd7, 2'd1, 2'd2, 2'd3, 3'd1, 8'h33);
        step();
        cmd_valid = 1'b0;
        check("ill_flags", {29'd0, done, err, imm_oe}, 32'd6);
        check("ill_strobes", {4'd0, rdata, wdata, raddr, waddr, alu_r_a, alu_r_b, alu_w}, 32'd0);
        step();
        check("ill_after", {30'd0, done, err}, 32'd0);

        // Random command stream with invariants checked every cycle
        inv_en = 1'b1;
        for (int n = 0; n < 300; n++) begin
            issue(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
            cmd_valid = 1'($urandom_range(0, 1));
            step();
        end
        cmd_valid = 1'b0;
        repeat (4) step();
        inv_en = 1'b0;

        // Reset during SWAP EX2 must abort before the alu_w leg
        issue(3'd4, 2'd0, 2'd1, 2'd2, 3'd0, 8'h00);
        step();
        cmd_valid = 1'b0;
        step();
        check("abort_pre", {24'd0, rdata, wdata}, {24'd0, 4'b0100, 4'b0010});
        watch = 1'b1;
        rst_n = 1'b0;
        #1;
        check("abort_strobes", {4'd0, rdata, wdata, raddr, waddr, alu_r_a, alu_r_b, alu_w}, 32'd0);
        check("abort_flags", {29'd0, alu_latch, imm_oe, done}, 32'd0);
        #10;
        rst_n = 1'b1;
        repeat (5) step();
        check("abort_no_aluw", {31'd0, alu_w_seen}, 32'd0);
        check("abort_ready", {31'd0, cmd_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
